// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified transmitter. BCK and LCK are divided down from CLK;
// sample pairs arrive through a one-entry pending buffer and are loaded at frame boundaries.
module i2s_tx_stereo #(
    parameter int DATA_W  = 16,
    parameter int SLOT_W  = 32,
    parameter int BCK_DIV = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              MODE,
    input  logic [DATA_W-1:0] L_SMP,
    input  logic [DATA_W-1:0] R_SMP,
    input  logic              SMP_VALID,
    output logic              SMP_READY,
    output logic              BCK,
    output logic              LCK,
    output logic              DIN,
    output logic              UNDERRUN
);
    localparam int FRAME = 2 * SLOT_W;
    localparam int BW    = (FRAME > 2) ? $clog2(FRAME) : 1;
    localparam int DW    = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);

    logic [DW-1:0]     div_cnt, div_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic              en_q;
    logic              pend_full, pend_nxt;
    logic [DATA_W-1:0] pend_l, pend_r;
    logic [DATA_W-1:0] act_l, act_r, act_l_nxt, act_r_nxt;
    logic              mode_q, mode_nxt;
    logic              carry, carry_nxt;
    logic              accept, tick, load;
    logic              bck_nxt, lck_nxt, din_nxt, underrun_nxt;
    logic [BW-1:0]     pos, k;
    logic [DATA_W-1:0] ch, shifted;

    // Handshake: a pair transfers on a CLK edge where SMP_VALID && SMP_READY;
    // SMP_READY is the registered inverse of pend_full, so a full buffer never accepts.
    always_comb begin
        accept = SMP_VALID && SMP_READY;
        tick   = EN && (div_cnt == DIV_LAST);
        load   = (EN && !en_q) || (tick && (bit_cnt == BIT_LAST));

        div_nxt = '0;
        bit_nxt = '0;
        if (EN) begin
            div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            bit_nxt = bit_cnt;
            if (tick) begin
                bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
            end
        end

        pend_nxt = pend_full;
        if (accept) begin
            pend_nxt = 1'b1;
        end else if (load) begin
            pend_nxt = 1'b0;
        end

        act_l_nxt    = act_l;
        act_r_nxt    = act_r;
        mode_nxt     = mode_q;
        carry_nxt    = carry;
        underrun_nxt = 1'b0;
        if (load) begin
            carry_nxt = act_r[0];
            mode_nxt  = MODE;
            if (pend_full) begin
                act_l_nxt = pend_l;
                act_r_nxt = pend_r;
            end else begin
                act_l_nxt    = '0;
                act_r_nxt    = '0;
                underrun_nxt = 1'b1;
            end
        end

        // Philips framing lags the slot by one bit; the shift leaves zeros past DATA_W.
        pos = bit_nxt;
        if (!mode_nxt) begin
            pos = (bit_nxt == '0) ? BIT_LAST : bit_nxt - BW'(1);
        end
        if (pos >= SLOT_LEN) begin
            ch = act_r_nxt;
            k  = pos - SLOT_LEN;
        end else begin
            ch = act_l_nxt;
            k  = pos;
        end
        shifted = ch << k;
        din_nxt = EN && shifted[DATA_W-1];
        if (!mode_nxt && (bit_nxt == '0)) begin
            din_nxt = EN && (DATA_W == SLOT_W) && carry_nxt;
        end

        bck_nxt = EN && (div_nxt >= DIV_HALF);
        lck_nxt = EN && (bit_nxt >= SLOT_LEN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            en_q      <= 1'b0;
            pend_full <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
            act_l     <= '0;
            act_r     <= '0;
            mode_q    <= 1'b0;
            carry     <= 1'b0;
            SMP_READY <= 1'b0;
            BCK       <= 1'b0;
            LCK       <= 1'b0;
            DIN       <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            en_q      <= EN;
            pend_full <= pend_nxt;
            act_l     <= act_l_nxt;
            act_r     <= act_r_nxt;
            mode_q    <= mode_nxt;
            carry     <= carry_nxt;
            SMP_READY <= !pend_nxt;
            BCK       <= bck_nxt;
            LCK       <= lck_nxt;
            DIN       <= din_nxt;
            UNDERRUN  <= underrun_nxt;
            if (accept) begin
                pend_l <= L_SMP;
                pend_r <= R_SMP;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: a default instance (16/32/8) and a full-slot instance (24/24/4)
// whose serial frames are compared against a bit-position model of the framing rules.
`timescale 1ns/1ps
module tb_i2s_tx_stereo;
  // clock / reset
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // instance A: defaults
  logic en_a, mode_a, valid_a, ready_a, bck_a, lck_a, din_a, ur_a;
  logic [15:0] l_a, r_a;
  // instance B: DATA_W = SLOT_W = 24, BCK_DIV = 4
  logic en_b, mode_b, valid_b, ready_b, bck_b, lck_b, din_b, ur_b;
  logic [23:0] l_b, r_b;

  i2s_tx_stereo dut_a (
    .CLK(CLK), .RST_N(RST_N), .EN(en_a), .MODE(mode_a), .L_SMP(l_a), .R_SMP(r_a),
    .SMP_VALID(valid_a), .SMP_READY(ready_a), .BCK(bck_a), .LCK(lck_a), .DIN(din_a),
    .UNDERRUN(ur_a));

  i2s_tx_stereo #(.DATA_W(24), .SLOT_W(24), .BCK_DIV(4)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .EN(en_b), .MODE(mode_b), .L_SMP(l_b), .R_SMP(r_b),
    .SMP_VALID(valid_b), .SMP_READY(ready_b), .BCK(bck_b), .LCK(lck_b), .DIN(din_b),
    .UNDERRUN(ur_b));

  // scoreboard queues: {L, R} of every accepted pair, in order
  logic [31:0] exp_qa[$];
  logic [47:0] exp_qb[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: bit b of a frame (b = BCK period since LCK fell) from the framing rules.
  function automatic logic [63:0] model_frame(input logic [31:0] l, input logic [31:0] r,
                                              input logic mode, input logic last_r_lsb,
                                              input int dw, input int sw);
    logic [63:0] f;
    logic [31:0] ch;
    int p, k;
    f = '0;
    for (int b = 0; b < 2 * sw; b++) begin
      p = mode ? b : (b + 2 * sw - 1) % (2 * sw);
      ch = (p < sw) ? l : r;
      k = p % sw;
      f[b] = (k < dw) ? ch[dw-1-k] : 1'b0;
    end
    if (!mode) f[0] = (dw == sw) ? last_r_lsb : 1'b0;
    return f;
  endfunction

  function automatic logic [63:0] lck_pattern(input int sw);
    logic [63:0] v;
    v = '0;
    for (int b = sw; b < 2 * sw; b++) v[b] = 1'b1;
    return v;
  endfunction

  // monitor A: samples DIN/LCK at each BCK rise, one frame at a time
  int idx_a = 0;
  int ur_cnt_a = 0;
  logic bck_prev_a, ur_flag_a, last_r_a;
  logic [31:0] pr_a;
  logic [63:0] got_din_a, got_lck_a, exp_fr_a;
  always @(posedge CLK) begin
    #1;
    if (!RST_N || !en_a) begin
      idx_a = 0;
      ur_flag_a = 1'b0;
      bck_prev_a = 1'b0;
      if (!RST_N) last_r_a = 1'b0;
    end else begin
      if (ur_a) begin
        ur_flag_a = 1'b1;
        ur_cnt_a++;
      end
      if (bck_a && !bck_prev_a) begin
        if (idx_a == 0) begin
          if (ur_flag_a) pr_a = '0;
          else if (exp_qa.size() > 0) pr_a = exp_qa.pop_front();
          else begin
            pr_a = '0;
            checks++;
            failures++;
            $display("FAIL frame_source_a got=frame_without_underrun exp=underrun_or_queued_pair");
          end
          exp_fr_a = model_frame({16'h0, pr_a[31:16]}, {16'h0, pr_a[15:0]}, mode_a, last_r_a, 16, 32);
          last_r_a = pr_a[0];
          ur_flag_a = 1'b0;
          got_din_a = '0;
          got_lck_a = '0;
        end
        got_din_a[idx_a] = din_a;
        got_lck_a[idx_a] = lck_a;
        idx_a++;
        if (idx_a == 64) begin
          check("frame_din_a", got_din_a, exp_fr_a);
          check("frame_lck_a", got_lck_a, lck_pattern(32));
          idx_a = 0;
        end
      end
      bck_prev_a = bck_a;
    end
  end

  // monitor B: same framing with a 48-bit frame
  int idx_b = 0;
  int frames_b = 0;
  logic carry_b = 1'b0;
  logic bck_prev_b, ur_flag_b, last_r_b;
  logic [47:0] pr_b;
  logic [63:0] got_din_b, got_lck_b, exp_fr_b;
  always @(posedge CLK) begin
    #1;
    if (!RST_N || !en_b) begin
      idx_b = 0;
      ur_flag_b = 1'b0;
      bck_prev_b = 1'b0;
      if (!RST_N) last_r_b = 1'b0;
    end else begin
      if (ur_b) ur_flag_b = 1'b1;
      if (bck_b && !bck_prev_b) begin
        if (idx_b == 0) begin
          if (ur_flag_b) pr_b = '0;
          else if (exp_qb.size() > 0) pr_b = exp_qb.pop_front();
          else begin
            pr_b = '0;
            checks++;
            failures++;
            $display("FAIL frame_source_b got=frame_without_underrun exp=underrun_or_queued_pair");
          end
          exp_fr_b = model_frame({8'h0, pr_b[47:24]}, {8'h0, pr_b[23:0]}, mode_b, last_r_b, 24, 24);
          last_r_b = pr_b[0];
          ur_flag_b = 1'b0;
          got_din_b = '0;
          got_lck_b = '0;
        end
        got_din_b[idx_b] = din_b;
        got_lck_b[idx_b] = lck_b;
        idx_b++;
        if (idx_b == 48) begin
          check("frame_din_b", got_din_b, exp_fr_b);
          check("frame_lck_b", got_lck_b, lck_pattern(24));
          if (frames_b == 1) carry_b = got_din_b[0];
          frames_b++;
          idx_b = 0;
        end
      end
      bck_prev_b = bck_b;
    end
  end

  // driver: present a pair, push it to the scoreboard on the accepting edge
  task automatic send(input int which, input logic [23:0] l, input logic [23:0] r, input bit hold);
    bit rdy, done;
    int n;
    done = 1'b0;
    n = 0;
    @(negedge CLK);
    if (which == 0) begin
      valid_a = 1'b1; l_a = l[15:0]; r_a = r[15:0];
    end else begin
      valid_b = 1'b1; l_b = l; r_b = r;
    end
    while (!done) begin
      rdy = (which == 0) ? ready_a : ready_b;
      @(posedge CLK);
      if (rdy) begin
        if (which == 0) exp_qa.push_back({l[15:0], r[15:0]});
        else exp_qb.push_back({l, r});
        done = 1'b1;
      end else begin
        n++;
        if (n > 3000) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout got=ready_low exp=ready_within_3000_cycles");
          done = 1'b1;
        end else @(negedge CLK);
      end
    end
    @(negedge CLK);
    check("ready_drop", (which == 0) ? ready_a : ready_b, 64'd0);
    if (!hold) begin
      if (which == 0) valid_a = 1'b0;
      else valid_b = 1'b0;
    end
  endtask

  task automatic wait_empty(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? exp_qa.size() : exp_qb.size()) > 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (((which == 0) ? exp_qa.size() : exp_qb.size()) > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=pairs_pending exp=all_transmitted which=%0d", which);
    end
  endtask

  task automatic wait_idx_a(input int target);
    int n;
    n = 0;
    while (idx_a != target && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (idx_a != target) begin
      checks++;
      failures++;
      $display("FAIL idx_timeout got=%0d exp=%0d", idx_a, target);
    end
  endtask

  // cycles between two successive rises of BCK (sel=0) or LCK (sel=1) of instance A
  task automatic measure_a(input int sel, output int period);
    logic prev, cur;
    int n, rises;
    n = 0; rises = 0; period = 0;
    @(negedge CLK);
    prev = (sel == 0) ? bck_a : lck_a;
    while (rises < 2 && n < 3000) begin
      @(negedge CLK);
      n++;
      cur = (sel == 0) ? bck_a : lck_a;
      if (rises == 1) period++;
      if (cur && !prev) rises++;
      prev = cur;
    end
  endtask

  int per, ur0, ur_win, din_ones;
  logic [15:0] ra, rb;
  initial begin
    RST_N = 1'b0;
    en_a = 0; mode_a = 0; valid_a = 0; l_a = '0; r_a = '0;
    en_b = 0; mode_b = 0; valid_b = 0; l_b = '0; r_b = '0;
    repeat (3) @(negedge CLK);
    check("reset_out_a", {bck_a, lck_a, din_a, ur_a, ready_a}, 64'd0);
    check("reset_out_b", {bck_b, lck_b, din_b, ur_b, ready_b}, 64'd0);
    RST_N = 1'b1;
    #1 check("ready_before_edge", ready_a, 64'd0);
    @(negedge CLK);
    check("ready_after_edge", ready_a, 64'd1);

    // Philips framing, directed pair loaded before EN, then random pairs
    send(0, 24'h008001, 24'h007FFE, 0);
    @(negedge CLK);
    en_a = 1'b1;
    measure_a(0, per);
    check("bck_period", per, 64'd8);
    measure_a(1, per);
    check("lck_period", per, 64'd512);
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      send(0, {8'h0, ra}, {8'h0, rb}, 0);
    end
    wait_empty(0, 4000);

    // no samples: one underrun per frame, silent line
    ur0 = ur_cnt_a;
    for (int n = 0; n < 1200 && ur_cnt_a == ur0; n++) @(negedge CLK);
    ur_win = 0; din_ones = 0;
    repeat (2048) begin
      @(negedge CLK);
      if (ur_a) ur_win++;
      if (din_a) din_ones++;
    end
    check("underrun_per_frame", ur_win, 64'd4);
    check("mute_din_zero", din_ones, 64'd0);

    // idle, then left-justified framing with a pair accepted while idle
    @(negedge CLK);
    en_a = 1'b0;
    repeat (20) @(negedge CLK);
    check("idle_outputs", {bck_a, lck_a, din_a}, 64'd0);
    mode_a = 1'b1;
    send(0, 24'h008001, 24'h007FFE, 0);
    @(negedge CLK);
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      send(0, {8'h0, ra}, {8'h0, rb}, 0);
    end
    wait_empty(0, 4000);

    // VALID held high across three distinct pairs
    ra = 16'($urandom);
    send(0, {8'h0, ra}, 24'h00A5A5, 1);
    ur0 = ur_cnt_a;
    send(0, 24'h001234, {8'h0, ra ^ 16'hFFFF}, 1);
    send(0, 24'h00C0DE, 24'h000001, 0);
    wait_empty(0, 2500);
    check("no_underrun_streaming", ur_cnt_a - ur0, 64'd0);
    repeat (600) @(negedge CLK);

    // full-width slot: right LSB carried into bit 0 of the next frame
    send(1, 24'($urandom), 24'h000001, 0);
    @(negedge CLK);
    en_b = 1'b1;
    send(1, 24'($urandom), 24'($urandom) & 24'hFFFFFE, 0);
    send(1, 24'($urandom), 24'($urandom), 0);
    wait_empty(1, 1500);
    repeat (300) @(negedge CLK);
    check("carry_bit_b", carry_b, 64'd1);
    @(negedge CLK);
    en_b = 1'b0;

    // reset mid-frame with a pair pending
    wait_idx_a(5);
    send(0, 24'($urandom), 24'($urandom), 0);
    wait_idx_a(21);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check("async_reset_out", {bck_a, lck_a, din_a, ur_a, ready_a}, 64'd0);
    exp_qa.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    ur0 = ur_cnt_a;
    #1 check("ready_before_edge_rst", ready_a, 64'd0);
    @(negedge CLK);
    check("ready_after_edge_rst", ready_a, 64'd1);
    repeat (20) @(negedge CLK);
    check("first_frame_underrun", ur_cnt_a - ur0, 64'd1);
    ra = 16'($urandom); rb = 16'($urandom);
    send(0, {8'h0, ra}, {8'h0, rb}, 0);
    wait_empty(0, 1500);
    repeat (600) @(negedge CLK);
    en_a = 1'b0;
    @(negedge CLK);
    check("queues_drained", exp_qa.size() + exp_qb.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
